// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types and the opid ordering helpers used by the arbiter
// and by every execution unit that needs to agree on what a redirect kills.
package wb_arbiter_pkg;

    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [31:0] data;
    } exe_bundle_t;

    // Age is measured from topid modulo opsz, so younger-than-redirect wraps correctly.
    function automatic logic squashed(red_bundle_t r, logic [15:0] opid, int unsigned opsz);
        logic [15:0] mask;
        logic [15:0] d_op;
        logic [15:0] d_red;
        mask  = 16'(opsz - 1);
        d_op  = (opid - r.topid) & mask;
        d_red = (r.opid - r.topid) & mask;
        return r.opid[15] && opid[15] && (d_op > d_red);
    endfunction

    function automatic logic [31:0] sat_add32(logic [31:0] a, logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/wb_arbiter_lane_sel.sv
// In-order lane chain for one unit: claims a prefix of valid lanes, letting
// squashed lanes through for free and stopping when writeback slots run out.
module wb_lane_sel #(
    parameter int ewd = 4,
    parameter int cw  = 3
) (
    input  logic [ewd-1:0] lane_valid,
    input  logic [ewd-1:0] lane_squash,
    input  logic [cw-1:0]  free_slots,
    output logic [ewd-1:0] claim,
    output logic [cw-1:0]  grant_cnt
);

    always_comb begin
        logic          run;
        logic [cw-1:0] left;
        claim     = '0;
        grant_cnt = '0;
        run       = 1'b1;
        left      = free_slots;
        for (int j = 0; j < ewd; j++) begin
            if (run && lane_valid[j]) begin
                if (lane_squash[j]) begin
                    claim[j] = 1'b1;
                end else if (left != '0) begin
                    claim[j]  = 1'b1;
                    left      = left - cw'(1);
                    grant_cnt = grant_cnt + cw'(1);
                end else begin
                    run = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: packs unit results into wbw registered slots,
// dropping results that a pending redirect has squashed.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int nfu  = 3,
    parameter int ewd  = 4,
    parameter int wbw  = 4,
    parameter int opsz = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  red_bundle_t    redir,
    input  exe_bundle_t    resp  [nfu][ewd],
    output logic [ewd-1:0] claim [nfu],
    output exe_bundle_t    wb    [wbw],
    output logic [31:0]    n_wb,
    output logic [31:0]    n_squash
);

    localparam int cw = $clog2(wbw + 1);
    localparam int pw = (nfu > 1) ? $clog2(nfu) : 1;

    logic [pw-1:0]  rr_ptr;
    logic [pw-1:0]  next_rr;
    logic [ewd-1:0] lane_valid  [nfu];
    logic [ewd-1:0] lane_squash [nfu];
    logic [pw-1:0]  sel_unit    [nfu];
    logic [ewd-1:0] sel_claim   [nfu];
    logic [cw-1:0]  sel_gcnt    [nfu];
    logic [cw-1:0]  sel_base    [nfu];
    exe_bundle_t    next_wb     [wbw];
    logic [31:0]    grant_tot;
    logic [31:0]    squash_tot;

    always_comb begin
        for (int u = 0; u < nfu; u++) begin
            for (int j = 0; j < ewd; j++) begin
                lane_valid[u][j]  = resp[u][j].opid[15];
                lane_squash[u][j] = squashed(redir, resp[u][j].opid, opsz);
            end
        end
    end

    // Stage k serves unit (rr_ptr + k) mod nfu; free slots ripple down the stages.
    for (genvar k = 0; k < nfu; k++) begin : g_stage
        logic [pw:0]   usum;
        logic [pw-1:0] unit;
        logic [cw-1:0] free;
        logic [cw-1:0] gcnt;

        assign usum = {1'b0, rr_ptr} + (pw+1)'(k);
        assign unit = (usum >= (pw+1)'(nfu)) ? pw'(usum - (pw+1)'(nfu)) : pw'(usum);

        if (k == 0) begin : g_first
            assign free = cw'(wbw);
        end else begin : g_chain
            assign free = g_stage[k-1].free - g_stage[k-1].gcnt;
        end

        wb_lane_sel #(.ewd(ewd), .cw(cw)) u_sel (
            .lane_valid (lane_valid[unit]),
            .lane_squash(lane_squash[unit]),
            .free_slots (free),
            .claim      (sel_claim[k]),
            .grant_cnt  (gcnt)
        );

        assign sel_unit[k] = unit;
        assign sel_gcnt[k] = gcnt;
        assign sel_base[k] = cw'(wbw) - free;
    end

    always_comb begin
        for (int u = 0; u < nfu; u++) begin
            claim[u] = '0;
        end
        if (rst) begin
            for (int k = 0; k < nfu; k++) begin
                claim[sel_unit[k]] = sel_claim[k];
            end
        end
    end

    // Granted lanes fill slots in service order starting from each stage's base.
    always_comb begin
        int slot;
        slot       = 0;
        grant_tot  = '0;
        squash_tot = '0;
        next_rr    = rr_ptr;
        for (int i = 0; i < wbw; i++) begin
            next_wb[i] = '0;
        end
        for (int k = 0; k < nfu; k++) begin
            slot = int'(sel_base[k]);
            for (int j = 0; j < ewd; j++) begin
                if (sel_claim[k][j]) begin
                    if (lane_squash[sel_unit[k]][j]) begin
                        squash_tot = squash_tot + 32'd1;
                    end else begin
                        next_wb[slot] = resp[sel_unit[k]][j];
                        slot          = slot + 1;
                    end
                end
            end
            grant_tot = grant_tot + 32'(sel_gcnt[k]);
            if (sel_gcnt[k] != '0) begin
                next_rr = (sel_unit[k] == pw'(nfu - 1)) ? '0 : sel_unit[k] + pw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < wbw; i++) begin
                wb[i] <= '0;
            end
            rr_ptr   <= '0;
            n_wb     <= '0;
            n_squash <= '0;
        end else begin
            wb       <= next_wb;
            rr_ptr   <= next_rr;
            n_wb     <= sat_add32(n_wb, grant_tot);
            n_squash <= sat_add32(n_squash, squash_tot);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter: a queue-based reference model
// predicts claims, writeback slots and counters; a negedge monitor compares.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int nfu  = 3;
    localparam int ewd  = 4;
    localparam int wbw  = 4;
    localparam int opsz = 64;
    localparam int half = 5;

    typedef struct packed {
        logic [nfu-1:0][ewd-1:0] claim;
        exe_bundle_t [wbw-1:0]   wb;
        logic [31:0]             nwb;
        logic [31:0]             nsq;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    red_bundle_t    redir = '0;
    exe_bundle_t    resp  [nfu][ewd];
    logic [ewd-1:0] claim [nfu];
    exe_bundle_t    wb    [wbw];
    logic [31:0]    n_wb;
    logic [31:0]    n_squash;

    exp_t        exp_q[$];
    int          checks = 0;
    int          fails  = 0;

    red_bundle_t stim_redir;
    exe_bundle_t stim_resp [nfu][ewd];
    logic        stim_rst;

    exe_bundle_t m_wb [wbw];
    exe_bundle_t m_nxt_wb [wbw];
    int          m_rr, m_nxt_rr;
    longint      m_nwb, m_nsq, m_nxt_nwb, m_nxt_nsq;
    bit          m_commit = 1'b0;

    wb_arbiter #(.nfu(nfu), .ewd(ewd), .wbw(wbw), .opsz(opsz)) dut (
        .clk     (clk),
        .rst     (rst),
        .redir   (redir),
        .resp    (resp),
        .claim   (claim),
        .wb      (wb),
        .n_wb    (n_wb),
        .n_squash(n_squash)
    );

    initial forever #half clk = ~clk;

    // A result is killed when it is strictly younger than the redirect point, ages taken mod opsz.
    function automatic bit modelSquashed(logic [15:0] op);
        int d_op, d_red;
        if (!stim_redir.opid[15] || !op[15]) return 1'b0;
        d_op  = ((int'(op) % opsz) - (int'(stim_redir.topid) % opsz) + opsz) % opsz;
        d_red = ((int'(stim_redir.opid) % opsz) - (int'(stim_redir.topid) % opsz) + opsz) % opsz;
        return d_op >= d_red + 1;
    endfunction

    task automatic modelStep(output logic [nfu-1:0][ewd-1:0] c);
        int free, nslot, last, u;
        c     = '0;
        free  = wbw;
        nslot = 0;
        last  = -1;
        for (int i = 0; i < wbw; i++) m_nxt_wb[i] = '0;
        m_nxt_nsq = m_nsq;
        for (int k = 0; k < nfu; k++) begin
            u = (m_rr + k) % nfu;
            for (int j = 0; j < ewd; j++) begin
                if (!stim_resp[u][j].opid[15]) break;
                if (modelSquashed(stim_resp[u][j].opid)) begin
                    c[u][j] = 1'b1;
                    m_nxt_nsq++;
                    continue;
                end
                if (free == 0) break;
                c[u][j] = 1'b1;
                m_nxt_wb[nslot] = stim_resp[u][j];
                nslot++;
                free--;
                last = u;
            end
        end
        m_nxt_rr  = (last >= 0) ? (last + 1) % nfu : m_rr;
        m_nxt_nwb = m_nwb + nslot;
        if (m_nxt_nwb > 64'hFFFF_FFFF) m_nxt_nwb = 64'hFFFF_FFFF;
        if (m_nxt_nsq > 64'hFFFF_FFFF) m_nxt_nsq = 64'hFFFF_FFFF;
    endtask

    task automatic applyStimulus();
        exp_t e;
        logic [nfu-1:0][ewd-1:0] c;
        @(posedge clk);
        #1;
        if (m_commit) begin
            m_wb  = m_nxt_wb;
            m_rr  = m_nxt_rr;
            m_nwb = m_nxt_nwb;
            m_nsq = m_nxt_nsq;
        end
        rst   = stim_rst;
        redir = stim_redir;
        resp  = stim_resp;
        if (!stim_rst) begin
            for (int i = 0; i < wbw; i++) m_wb[i] = '0;
            m_rr     = 0;
            m_nwb    = 0;
            m_nsq    = 0;
            m_commit = 1'b0;
            c        = '0;
        end else begin
            modelStep(c);
            m_commit = 1'b1;
        end
        e.claim = c;
        for (int i = 0; i < wbw; i++) e.wb[i] = m_wb[i];
        e.nwb = m_nwb[31:0];
        e.nsq = m_nsq[31:0];
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [nfu-1:0][ewd-1:0] act_c;
        exe_bundle_t [wbw-1:0]   act_wb;
        bit ok;
        ok = 1'b1;
        for (int u = 0; u < nfu; u++) act_c[u] = claim[u];
        for (int i = 0; i < wbw; i++) begin
            act_wb[i] = wb[i];
            if (wb[i].opid !== e.wb[i].opid) ok = 1'b0;
            if (e.wb[i].opid[15] && wb[i].data !== e.wb[i].data) ok = 1'b0;
        end
        checks++;
        if (act_c !== e.claim) begin
            fails++;
            $display("[TB] FAIL claim at %0t: got %h expected %h", $time, act_c, e.claim);
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL wb at %0t: got %h expected %h", $time, act_wb, e.wb);
        end
        checks++;
        if (n_wb !== e.nwb) begin
            fails++;
            $display("[TB] FAIL n_wb at %0t: got %0d expected %0d", $time, n_wb, e.nwb);
        end
        checks++;
        if (n_squash !== e.nsq) begin
            fails++;
            $display("[TB] FAIL n_squash at %0t: got %0d expected %0d", $time, n_squash, e.nsq);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
        end
    end

    task automatic clearStim();
        stim_rst   = 1'b1;
        stim_redir = '0;
        for (int u = 0; u < nfu; u++)
            for (int j = 0; j < ewd; j++) stim_resp[u][j] = '0;
    endtask

    task automatic setLane(input int u, input int j, input logic [15:0] op);
        stim_resp[u][j].opid = op;
        stim_resp[u][j].data = $urandom;
    endtask

    task automatic fillAll(input int lanes);
        for (int u = 0; u < nfu; u++)
            for (int j = 0; j < lanes; j++) setLane(u, j, 16'h8000 | 16'(u * 8 + j));
    endtask

    task automatic resetPulse();
        clearStim();
        stim_rst = 1'b0;
        applyStimulus();
        clearStim();
    endtask

    initial begin
        int guard;
        for (int u = 0; u < nfu; u++)
            for (int j = 0; j < ewd; j++) resp[u][j] = '0;
        clearStim();
        // Reset with live lanes: claims must stay low
        stim_rst = 1'b0;
        fillAll(ewd);
        applyStimulus();
        applyStimulus();

        // Single lane result and its writeback
        clearStim();
        setLane(0, 0, 16'h8005);
        applyStimulus();
        clearStim();
        applyStimulus();

        // Slot exhaustion across units from rr_ptr = 0
        resetPulse();
        fillAll(3);
        applyStimulus();
        clearStim();
        fillAll(3);
        applyStimulus();
        clearStim();
        applyStimulus();

        // Redirect squashes the younger of two results
        resetPulse();
        stim_redir.opid  = 16'h8010;
        stim_redir.topid = 16'h8000;
        setLane(0, 0, 16'h8008);
        setLane(0, 1, 16'h8012);
        applyStimulus();
        clearStim();
        applyStimulus();

        // Invalid lane 0 blocks lane 1
        setLane(1, 1, 16'h8003);
        applyStimulus();
        clearStim();
        applyStimulus();

        // Wrap-around ordering
        stim_redir.opid  = 16'h803F;
        stim_redir.topid = 16'h803E;
        setLane(2, 0, 16'h8001);
        setLane(2, 1, 16'h803E);
        applyStimulus();
        clearStim();
        applyStimulus();

        // Reset while wb holds valid slots, then grant again from unit 0
        fillAll(2);
        applyStimulus();
        clearStim();
        stim_rst = 1'b0;
        applyStimulus();
        clearStim();
        fillAll(ewd);
        applyStimulus();
        clearStim();
        applyStimulus();

        for (int n = 0; n < 400; n++) begin
            clearStim();
            stim_rst = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 1) != 0) begin
                stim_redir.opid  = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                stim_redir.topid = 16'($urandom);
            end
            for (int u = 0; u < nfu; u++)
                for (int j = 0; j < ewd; j++)
                    if ($urandom_range(0, 3) != 0)
                        setLane(u, j, 16'h8000 | 16'($urandom_range(0, 16'h7FFF)));
            applyStimulus();
        end
        clearStim();
        applyStimulus();

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter nfu, default 3: number of execution units feeding writeback.
REQ-002 Parameter ewd, default 4: response lanes per execution unit.
REQ-003 Parameter wbw, default 4: writeback slots per cycle.
REQ-004 Parameter opsz, default 64: operation ID space; ordering uses the low $clog2(opsz) bits of opid.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 redir  input  red_bundle_t  redirect bundle (opid[15] = valid; opid and topid are used).
REQ-008 resp  input  exe_bundle_t [nfu][ewd]  unit results; lane valid when opid[15]=1.
REQ-009 claim  output  [nfu][ewd]  combinational; tells a unit that this cycle's lane result is taken.
REQ-010 wb  output  exe_bundle_t [wbw]  registered writeback slots; slot valid when opid[15]=1.
REQ-011 n_wb, n_squash  output  32 each  saturating counts of results written back and results dropped.

Function
REQ-012 Squash predicate squashed(opid), computed modulo opsz, is true when all hold: redir.opid[15]; opid[15]; (opid-topid) >= (redir.opid-topid)+1.
REQ-013 Lane claiming is in order: lane j of unit u is claimable only if it is valid and lanes 0..j-1 of u are claimed this cycle.
REQ-014 A valid, squashed lane is claimed, uses no wb slot, and increments n_squash.
REQ-015 A valid, unsquashed lane needs a free wb slot; if none is free, that lane and all higher lanes of the unit are not claimed.
REQ-016 Units are served in round-robin order starting at rr_ptr; each unit is served fully (all claimable lanes) before the next unit.
REQ-017 At most wbw unsquashed results are granted per cycle; granted results fill wb slots 0..k-1 in service order, and the remaining slots carry opid=0.
REQ-018 Latency: a result claimed in cycle t appears on wb in cycle t+1. No backpressure exists from wb.
REQ-019 A granted result whose opid satisfies squashed() in its grant cycle is stored with opid=0.
REQ-020 rr_ptr advances to (last unit granted at least one slot)+1 mod nfu; it is unchanged if nothing is granted.
REQ-021 n_wb increments by the number of valid wb slots loaded each cycle.
REQ-022 Both counters saturate at 2^32-1.
REQ-023 With no valid lanes: claim is all zero, next wb has all opid=0, and rr_ptr holds.
REQ-024 An invalid lane (opid[15]=0) breaks the in-order chain for its unit; higher lanes of that unit are not claimed.

Reset
REQ-025 While rst=0: wb=0, rr_ptr=0, n_wb=0, n_squash=0, and claim is forced to 0 regardless of resp.
REQ-026 Reset asserted mid-operation discards registered wb contents; results not claimed remain owned by their units.
REQ-027 The first grant after reset release starts at unit 0.

Structure
REQ-028 red_bundle_t, exe_bundle_t and the squashed() ordering function belong in package types; the function is shared with all execution units.
REQ-029 The per-unit in-order lane chain is one sub-module, wb_lane_sel: inputs are lane valid, lane squash and free-slot count; outputs are claim mask and grant count. It is instantiated nfu times in rotated order.
REQ-030 No further sub-modules; counters and the output register are inline.

Verification
REQ-031 Single unit, lane 0 valid, opid=0x8005, no redirect -> claim[0][0]=1 that cycle; next cycle wb[0].opid=0x8005, n_wb=1.
REQ-032 nfu=3, wbw=4, 3 valid lanes on every unit, rr_ptr=0 -> unit 0 lanes 0-2 and unit 1 lane 0 claimed; unit 1 lanes 1-2 and unit 2 not claimed; rr_ptr=2 next cycle.
REQ-033 Redirect with opid=0x8010, topid=0x8000, and unit 0 lanes carrying opids 0x8008 and 0x8012 -> both claimed; only 0x8008 written back; n_squash=1.
REQ-034 Lane 0 invalid, lane 1 valid -> lane 1 not claimed; wb all invalid.
REQ-035 Wrap-around: topid=0x803E, redir.opid=0x803F, lane opid=0x8001 (mod 64) -> lane squashed; lane opid=0x803E -> written back.
REQ-036 rst dropped while wb holds valid slots, then released -> wb=0, counters=0, and the first grant comes from unit 0.
